// File: rtl/ups_da_sched.sv
`default_nettype none
// ============================================================================
//  Module   : ups_da_sched
//  Purpose  : Two-channel DAC update scheduler. Host and control-loop codes
//             are coalesced into one pending slot per channel and issued to
//             the DAC serializer with a busy handshake, a busy-rise timeout
//             and a minimum idle gap between transactions.
//  Ports    : clk, rst_n (async assert, active-low), en (issue enable)
//             hst_dv0/1, hst_data0/1 : host update strobes and codes
//             ctl_dv0/1, ctl_data0/1 : control-loop update strobes and codes
//             da_busy                : serializer busy
//             da_dv0/1, da_data0/1   : issue strobes and held issued codes
//             pend, drop_cnt, err, err_clr, idle : status
//  Revision : 1.0 - initial release
// ============================================================================
module ups_da_sched #(
    parameter int GAP_CYC = 16,
    parameter int BUSY_TO = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        hst_dv0,
    input  logic        hst_dv1,
    input  logic [11:0] hst_data0,
    input  logic [11:0] hst_data1,
    input  logic        ctl_dv0,
    input  logic        ctl_dv1,
    input  logic [11:0] ctl_data0,
    input  logic [11:0] ctl_data1,
    input  logic        da_busy,
    output logic        da_dv0,
    output logic        da_dv1,
    output logic [11:0] da_data0,
    output logic [11:0] da_data1,
    output logic [1:0]  pend,
    output logic [7:0]  drop_cnt,
    output logic        err,
    input  logic        err_clr,
    output logic        idle
);

    localparam int c_gap_w = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam int c_tmr_w = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
    localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(GAP_CYC);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(BUSY_TO - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          pend_q, pend_d;
    logic [11:0]         pdata_q [2];
    logic [11:0]         pdata_d [2];
    logic [11:0]         hold_q  [2];
    logic [11:0]         hold_d  [2];
    logic [7:0]          drop_q, drop_d;
    logic                err_q, err_d;
    logic [c_tmr_w-1:0]  tmr_q, tmr_d;
    logic [c_gap_w-1:0]  gap_q, gap_d;

    logic [1:0]          w_hst_dv, w_ctl_dv, w_issuing;
    logic [11:0]         w_hst_data [2];
    logic [11:0]         w_ctl_data [2];
    logic [2:0]          w_drops;
    logic [8:0]          w_drop_sum;
    logic                w_timeout;

    assign w_hst_dv      = {hst_dv1, hst_dv0};
    assign w_ctl_dv      = {ctl_dv1, ctl_dv0};
    assign w_hst_data[0] = hst_data0;
    assign w_hst_data[1] = hst_data1;
    assign w_ctl_data[0] = ctl_data0;
    assign w_ctl_data[1] = ctl_data1;

    // Channels issued in the current cycle: every pending channel while in ISSUE.
    assign w_issuing = (state_q == ST_ISSUE) ? pend_q : 2'b00;

    // Pending slots, issued-code hold registers and drop accounting.
    always_comb begin
        pend_d  = pend_q;
        pdata_d = pdata_q;
        hold_d  = hold_q;
        w_drops = 3'd0;
        for (int k = 0; k < 2; k++) begin
            if (w_issuing[k]) begin
                hold_d[k] = pdata_q[k];
            end
            if (w_hst_dv[k] || w_ctl_dv[k]) begin
                // Host wins a same-cycle collision; the control code is lost.
                pend_d[k]  = 1'b1;
                pdata_d[k] = w_hst_dv[k] ? w_hst_data[k] : w_ctl_data[k];
                if (w_hst_dv[k] && w_ctl_dv[k]) begin
                    w_drops = w_drops + 3'd1;
                end
                // A refill of a channel that is leaving this cycle loses nothing.
                if (pend_q[k] && !w_issuing[k]) begin
                    w_drops = w_drops + 3'd1;
                end
            end else if (w_issuing[k]) begin
                pend_d[k] = 1'b0;
            end
        end
        w_drop_sum = {1'b0, drop_q} + {6'd0, w_drops};
        drop_d     = (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
    end

    // Transaction sequencing.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        gap_d     = gap_q;
        w_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && (pend_q != 2'b00) && !da_busy) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
                tmr_d   = '0;
            end
            ST_WAIT_BUSY: begin
                if (da_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmr_q == c_tmr_last) begin
                    w_timeout = 1'b1;
                    state_d   = ST_GAP;
                    gap_d     = c_gap_load;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!da_busy) begin
                    gap_d   = c_gap_load;
                    state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                // The cycle that sees the count at one (or zero after a
                // timeout with no gap) is the last GAP cycle.
                if (gap_q <= c_gap_w'(1)) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A timeout in the same cycle as err_clr keeps err set.
        err_d = w_timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 2'b00;
            pdata_q <= '{default: '0};
            hold_q  <= '{default: '0};
            drop_q  <= 8'd0;
            err_q   <= 1'b0;
            tmr_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pdata_q <= pdata_d;
            hold_q  <= hold_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
            tmr_q   <= tmr_d;
            gap_q   <= gap_d;
        end
    end

    assign da_dv0   = w_issuing[0];
    assign da_dv1   = w_issuing[1];
    assign da_data0 = w_issuing[0] ? pdata_q[0] : hold_q[0];
    assign da_data1 = w_issuing[1] ? pdata_q[1] : hold_q[1];
    assign pend     = pend_q;
    assign drop_cnt = drop_q;
    assign err      = err_q;
    assign idle     = (state_q == ST_IDLE) && (pend_q == 2'b00);

endmodule
`default_nettype wire

// File: tb/tb_ups_da_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ups_da_sched
//  Purpose  : Self-checking bench for ups_da_sched: directed vector table,
//             hand-written corner sequences and randomized traffic compared
//             every cycle against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ups_da_sched;

    localparam int GAP_CYC = 16;
    localparam int BUSY_TO = 8;

    logic        clk = 1'b0;
    logic        rst_n, en, da_busy, err_clr;
    logic        hst_dv0, hst_dv1, ctl_dv0, ctl_dv1;
    logic [11:0] hst_data0, hst_data1, ctl_data0, ctl_data1;
    logic        da_dv0, da_dv1, err, idle;
    logic [11:0] da_data0, da_data1;
    logic [1:0]  pend;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    ups_da_sched #(.GAP_CYC(GAP_CYC), .BUSY_TO(BUSY_TO)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hst_dv0(hst_dv0), .hst_dv1(hst_dv1),
        .hst_data0(hst_data0), .hst_data1(hst_data1),
        .ctl_dv0(ctl_dv0), .ctl_dv1(ctl_dv1),
        .ctl_data0(ctl_data0), .ctl_data1(ctl_data1),
        .da_busy(da_busy),
        .da_dv0(da_dv0), .da_dv1(da_dv1),
        .da_data0(da_data0), .da_data1(da_data1),
        .pend(pend), .drop_cnt(drop_cnt), .err(err), .err_clr(err_clr),
        .idle(idle)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, req);
        end
    endtask

    // ---------------- transaction-level reference model -------------------
    // A transaction is described by the cycle it issues in, whether busy has
    // been seen yet, and the first cycle a new issue decision may be made.
    int          m_t;
    bit          m_in_flight;
    int          m_issue_t;
    bit          m_seen_busy;
    int          m_earliest;
    bit   [1:0]  m_pend;
    logic [11:0] m_pdata [2];
    logic [11:0] m_held  [2];
    int          m_drops;
    bit          m_err;

    function automatic void model_reset();
        m_t = 0; m_in_flight = 0; m_issue_t = 0; m_seen_busy = 0; m_earliest = 0;
        m_pend = 2'b00; m_pdata[0] = '0; m_pdata[1] = '0;
        m_held[0] = '0; m_held[1] = '0; m_drops = 0; m_err = 0;
    endfunction

    function automatic void model_update();
        bit          is_issue = m_in_flight && (m_t == m_issue_t);
        bit          timeout  = 0;
        bit   [1:0]  h  = {hst_dv1, hst_dv0};
        bit   [1:0]  c  = {ctl_dv1, ctl_dv0};
        logic [11:0] hd [2];
        logic [11:0] cd [2];
        hd[0] = hst_data0; hd[1] = hst_data1; cd[0] = ctl_data0; cd[1] = ctl_data1;
        if (!m_in_flight) begin
            if (m_t >= m_earliest && en && m_pend != 2'b00 && !da_busy) begin
                m_in_flight = 1; m_issue_t = m_t + 1; m_seen_busy = 0;
            end
        end else if (m_t > m_issue_t) begin
            if (!m_seen_busy) begin
                if (da_busy) m_seen_busy = 1;
                else if (m_t - m_issue_t == BUSY_TO) begin
                    timeout = 1; m_in_flight = 0;
                    m_earliest = m_t + 1 + ((GAP_CYC > 0) ? GAP_CYC : 1);
                end
            end else if (!da_busy) begin
                m_in_flight = 0; m_earliest = m_t + 1 + GAP_CYC;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (is_issue && m_pend[k]) m_held[k] = m_pdata[k];
            if (h[k] || c[k]) begin
                if (h[k] && c[k]) m_drops++;
                if (m_pend[k] && !is_issue) m_drops++;
                m_pdata[k] = h[k] ? hd[k] : cd[k];
                m_pend[k]  = 1;
            end else if (is_issue) begin
                m_pend[k] = 0;
            end
        end
        if (timeout) m_err = 1;
        else if (err_clr) m_err = 0;
        m_t++;
    endfunction

    task automatic model_compare();
        bit          is_issue = m_in_flight && (m_t == m_issue_t);
        bit   [1:0]  e_dv = is_issue ? m_pend : 2'b00;
        logic [11:0] e_d0 = (is_issue && m_pend[0]) ? m_pdata[0] : m_held[0];
        logic [11:0] e_d1 = (is_issue && m_pend[1]) ? m_pdata[1] : m_held[1];
        bit          e_idle = !m_in_flight && (m_t >= m_earliest) && (m_pend == 2'b00);
        check("mdl_da_dv", {30'd0, da_dv1, da_dv0}, {30'd0, e_dv});
        check("mdl_da_data0", {20'd0, da_data0}, {20'd0, e_d0});
        check("mdl_da_data1", {20'd0, da_data1}, {20'd0, e_d1});
        check("mdl_pend", {30'd0, pend}, {30'd0, m_pend});
        check("mdl_drop_cnt", {24'd0, drop_cnt}, (m_drops > 255) ? 32'd255 : 32'(m_drops));
        check("mdl_err", {31'd0, err}, {31'd0, m_err});
        check("mdl_idle", {31'd0, idle}, {31'd0, e_idle});
    endtask

    // One clock: model consumes this cycle's inputs, DUT outputs compared after the edge.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        model_compare();
    endtask

    task automatic clear_strobes();
        hst_dv0 = 0; hst_dv1 = 0; ctl_dv0 = 0; ctl_dv1 = 0; err_clr = 0;
    endtask

    task automatic do_reset();
        clear_strobes();
        en = 1; da_busy = 0;
        hst_data0 = '0; hst_data1 = '0; ctl_data0 = '0; ctl_data1 = '0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_reset();
    endtask

    task automatic wait_dv(input int budget, input string name);
        int n = 0;
        while (!(da_dv0 || da_dv1) && n < budget) begin
            step();
            n++;
        end
        check(name, {31'd0, (da_dv0 || da_dv1)}, 32'd1);
    endtask

    // ---------------- directed vector table -------------------------------
    typedef struct {
        int          reps;
        bit          en, busy, clr;
        bit   [1:0]  hdv;
        bit   [11:0] hd0, hd1;
        bit   [1:0]  cdv;
        bit   [11:0] cd0, cd1;
        bit   [1:0]  e_dv;
        bit   [11:0] e_d0, e_d1;
        bit   [1:0]  e_pend;
        bit   [7:0]  e_drop;
        bit          e_err, e_idle;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          busy_left;
        int          t_first, t_second, dv_seen;
        int          busy_on;
        vec_t        v;

        // reps, en, busy, clr, hdv, hd0, hd1, cdv, cd0, cd1 | dv, d0, d1, pend, drop, err, idle
        vecs.push_back('{1, 1'b1,1'b0,1'b0, 2'b00,12'h000,12'h000, 2'b01,12'h3A5,12'h000, 2'b00,12'h000,12'h000,2'b01,8'd0,1'b0,1'b0});
        vecs.push_back('{1, 1'b1,1'b0,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b01,12'h3A5,12'h000,2'b01,8'd0,1'b0,1'b0});
        vecs.push_back('{1, 1'b1,1'b0,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b00,12'h3A5,12'h000,2'b00,8'd0,1'b0,1'b0});
        vecs.push_back('{1, 1'b1,1'b1,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b00,12'h3A5,12'h000,2'b00,8'd0,1'b0,1'b0});
        vecs.push_back('{1, 1'b1,1'b1,1'b0, 2'b10,12'h000,12'h100, 2'b10,12'h000,12'h200, 2'b00,12'h3A5,12'h000,2'b10,8'd1,1'b0,1'b0});
        vecs.push_back('{1, 1'b1,1'b0,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b00,12'h3A5,12'h000,2'b10,8'd1,1'b0,1'b0});
        vecs.push_back('{16,1'b1,1'b0,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b00,12'h3A5,12'h000,2'b10,8'd1,1'b0,1'b0});
        vecs.push_back('{1, 1'b1,1'b0,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b10,12'h3A5,12'h100,2'b10,8'd1,1'b0,1'b0});
        vecs.push_back('{1, 1'b1,1'b0,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b00,12'h3A5,12'h100,2'b00,8'd1,1'b0,1'b0});
        vecs.push_back('{7, 1'b1,1'b0,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b00,12'h3A5,12'h100,2'b00,8'd1,1'b0,1'b0});
        vecs.push_back('{1, 1'b1,1'b0,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b00,12'h3A5,12'h100,2'b00,8'd1,1'b1,1'b0});
        vecs.push_back('{1, 1'b1,1'b0,1'b1, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b00,12'h3A5,12'h100,2'b00,8'd1,1'b0,1'b0});
        vecs.push_back('{15,1'b1,1'b0,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b00,12'h3A5,12'h100,2'b00,8'd1,1'b0,1'b1});
        vecs.push_back('{1, 1'b0,1'b0,1'b0, 2'b00,12'h000,12'h000, 2'b01,12'h0AB,12'h000, 2'b00,12'h3A5,12'h100,2'b01,8'd1,1'b0,1'b0});
        vecs.push_back('{3, 1'b0,1'b0,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b00,12'h3A5,12'h100,2'b01,8'd1,1'b0,1'b0});
        vecs.push_back('{1, 1'b1,1'b0,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b01,12'h0AB,12'h100,2'b01,8'd1,1'b0,1'b0});
        vecs.push_back('{1, 1'b1,1'b1,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b00,12'h0AB,12'h100,2'b00,8'd1,1'b0,1'b0});
        vecs.push_back('{1, 1'b1,1'b1,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b00,12'h0AB,12'h100,2'b00,8'd1,1'b0,1'b0});
        vecs.push_back('{1, 1'b1,1'b0,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b00,12'h0AB,12'h100,2'b00,8'd1,1'b0,1'b0});
        vecs.push_back('{16,1'b1,1'b0,1'b0, 2'b00,12'h000,12'h000, 2'b00,12'h000,12'h000, 2'b00,12'h0AB,12'h100,2'b00,8'd1,1'b0,1'b1});

        // ---- reset state, checked while reset is held ----
        clear_strobes();
        en = 1; da_busy = 0;
        hst_data0 = '0; hst_data1 = '0; ctl_data0 = '0; ctl_data1 = '0;
        rst_n = 0;
        @(posedge clk);
        #1;
        check("rst_da_dv", {30'd0, da_dv1, da_dv0}, 32'd0);
        check("rst_da_data0", {20'd0, da_data0}, 32'd0);
        check("rst_pend", {30'd0, pend}, 32'd0);
        check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        do_reset();

        // ---- directed table ----
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            en = v.en; da_busy = v.busy; err_clr = v.clr;
            hst_dv0 = v.hdv[0]; hst_dv1 = v.hdv[1]; hst_data0 = v.hd0; hst_data1 = v.hd1;
            ctl_dv0 = v.cdv[0]; ctl_dv1 = v.cdv[1]; ctl_data0 = v.cd0; ctl_data1 = v.cd1;
            for (int r = 0; r < v.reps; r++) step();
            check($sformatf("vec%0d_da_dv", i), {30'd0, da_dv1, da_dv0}, {30'd0, v.e_dv});
            check($sformatf("vec%0d_da_data0", i), {20'd0, da_data0}, {20'd0, v.e_d0});
            check($sformatf("vec%0d_da_data1", i), {20'd0, da_data1}, {20'd0, v.e_d1});
            check($sformatf("vec%0d_pend", i), {30'd0, pend}, {30'd0, v.e_pend});
            check($sformatf("vec%0d_drop_cnt", i), {24'd0, drop_cnt}, {24'd0, v.e_drop});
            check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, v.e_err});
            check($sformatf("vec%0d_idle", i), {31'd0, idle}, {31'd0, v.e_idle});
        end
        clear_strobes();

        // ---- coalescing and drop saturation ----
        do_reset();
        da_busy = 1;
        for (int i = 1; i <= 3; i++) begin
            ctl_dv0 = 1; ctl_data0 = 12'(i);
            step();
        end
        clear_strobes();
        check("coal_pend", {30'd0, pend}, 32'd1);
        check("coal_drops", {24'd0, drop_cnt}, 32'd2);
        da_busy = 0;
        wait_dv(10, "coal_issue_seen");
        check("coal_issue_dv", {30'd0, da_dv1, da_dv0}, 32'd1);
        check("coal_issue_data", {20'd0, da_data0}, 32'h003);
        da_busy = 1;
        step();
        step();
        for (int i = 0; i < 301; i++) begin
            ctl_dv0 = 1; ctl_data0 = 12'($urandom);
            step();
        end
        clear_strobes();
        check("coal_drop_sat", {24'd0, drop_cnt}, 32'd255);
        ctl_dv0 = 1; hst_dv0 = 1;
        step();
        clear_strobes();
        check("coal_drop_hold", {24'd0, drop_cnt}, 32'd255);

        // ---- pacing with a 3-cycle busy-rise delay and 40-cycle busy ----
        do_reset();
        ctl_dv0 = 1; ctl_data0 = 12'h111;
        step();
        clear_strobes();
        t_first = -1; t_second = -1; busy_on = 1 << 30;
        for (int c = 0; c < 300 && t_second < 0; c++) begin
            clear_strobes();
            if (da_dv0 && t_first < 0) begin
                t_first = c;
                check("pace_first_data", {20'd0, da_data0}, 32'h111);
                ctl_dv0 = 1; ctl_data0 = 12'h222;
                busy_on = c + 1 + 3;
            end else if (da_dv0) begin
                t_second = c;
                check("pace_second_data", {20'd0, da_data0}, 32'h222);
            end
            da_busy = (c >= busy_on) && (c < busy_on + 40);
            if (t_second < 0) begin
                step();
                if (c == t_first) begin
                    check("pace_refill_pend", {30'd0, pend}, 32'd1);
                    check("pace_refill_nodrop", {24'd0, drop_cnt}, 32'd0);
                end
            end
        end
        clear_strobes();
        da_busy = 0;
        check("pace_two_issues", {31'd0, (t_first >= 0 && t_second >= 0)}, 32'd1);
        check("pace_spacing_ok", {31'd0, ((t_second - t_first) >= 1 + 3 + 40 + GAP_CYC)}, 32'd1);

        // ---- reset during WAIT_DONE with both channels pending ----
        do_reset();
        ctl_dv0 = 1; ctl_data0 = 12'h0F0;
        step();
        clear_strobes();
        wait_dv(10, "rst_seq_issue_seen");
        da_busy = 1;
        step();
        step();
        hst_dv0 = 1; hst_data0 = 12'h555; hst_dv1 = 1; hst_data1 = 12'hAAA;
        step();
        clear_strobes();
        check("rst_seq_pend_before", {30'd0, pend}, 32'd3);
        check("rst_seq_data_before", {20'd0, da_data0}, 32'h0F0);
        #2 rst_n = 0;
        #1;
        check("rst_seq_da_dv", {30'd0, da_dv1, da_dv0}, 32'd0);
        check("rst_seq_da_data0", {20'd0, da_data0}, 32'd0);
        check("rst_seq_da_data1", {20'd0, da_data1}, 32'd0);
        check("rst_seq_pend", {30'd0, pend}, 32'd0);
        check("rst_seq_err", {31'd0, err}, 32'd0);
        check("rst_seq_idle", {31'd0, idle}, 32'd1);
        @(posedge clk);
        #1;
        da_busy = 0;
        rst_n = 1;
        model_reset();
        dv_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (da_dv0 || da_dv1) dv_seen++;
        end
        check("rst_seq_no_strobe", 32'(dv_seen), 32'd0);

        // ---- randomized traffic against the model ----
        do_reset();
        busy_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if (busy_left == 0) begin
                da_busy   = ($urandom_range(0, 1) == 1);
                busy_left = $urandom_range(1, 40);
            end
            busy_left--;
            en        = ($urandom_range(0, 9) != 0);
            err_clr   = ($urandom_range(0, 19) == 0);
            hst_dv0   = ($urandom_range(0, 7) == 0);
            hst_dv1   = ($urandom_range(0, 7) == 0);
            ctl_dv0   = ($urandom_range(0, 5) == 0);
            ctl_dv1   = ($urandom_range(0, 5) == 0);
            hst_data0 = 12'($urandom);
            hst_data1 = 12'($urandom);
            ctl_data0 = 12'($urandom);
            ctl_data1 = 12'($urandom);
            step();
        end
        clear_strobes();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ups_da_sched.md
UPS_DA_SCHED -- requirements
Module: ups_da_sched

Interface
Parameters:
REQ-001 The block SHALL provide parameter GAP_CYC, default 16: minimum idle clk cycles from da_busy falling to the next issue (0 = no gap).
REQ-002 The block SHALL provide parameter BUSY_TO, default 8: maximum clk cycles to wait for da_busy to rise after an issue.

Ports:
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low; deassertion synchronous to clk.
REQ-005 en  input  1  issue enable; 0 blocks new issues; latching continues.
REQ-006 hst_dv0/hst_dv1  input  1 each  host update strobe, channel 0/1, one cycle per value.
REQ-007 hst_data0/hst_data1  input  12 each  host code, valid with strobe.
REQ-008 ctl_dv0/ctl_dv1  input  1 each  control-loop update strobe, channel 0/1.
REQ-009 ctl_data0/ctl_data1  input  12 each  control-loop code, valid with strobe.
REQ-010 da_busy  input  1  busy from the DAC serializer.
REQ-011 da_dv0/da_dv1  output  1 each  one-cycle issue strobes to the serializer.
REQ-012 da_data0/da_data1  output  12 each  issued codes, held until the next issue.
REQ-013 pend  output  2  per-channel pending flags, bit k = channel k.
REQ-014 drop_cnt  output  8  saturating count of discarded (overwritten or lost) codes.
REQ-015 err  output  1  sticky busy-handshake timeout.
REQ-016 err_clr  input  1  clears err.
REQ-017 idle  output  1  high when the FSM is in IDLE and pend==0.

Function
REQ-018 Each channel k SHALL hold one pending register (pend[k], pdata_k), written on every clk regardless of FSM state.
REQ-019 Only hst_dvk high SHALL load hst_datak; only ctl_dvk high SHALL load ctl_datak; both high SHALL load hst_datak (host priority) and count one drop.
REQ-020 Loading while pend[k]=1 and channel k not being issued this cycle SHALL overwrite pdata_k and count one drop; a total of two drops SHALL add 2.
REQ-021 drop_cnt SHALL saturate at 255 and never wrap.
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
REQ-023 IDLE -> ISSUE SHALL occur when en=1, pend!=0, and da_busy=0; otherwise the FSM SHALL stay in IDLE.
REQ-024 ISSUE SHALL last exactly one cycle.
REQ-025 In ISSUE, da_dvk SHALL equal pend[k] and da_datak SHALL load pdata_k for each pending channel.
REQ-026 In ISSUE, each issued pend[k] SHALL clear, unless a new channel-k request arrives that cycle; then pend[k] stays 1 with the new data and no drop is counted.
REQ-027 ISSUE -> WAIT_BUSY SHALL clear the timeout timer.
REQ-028 In WAIT_BUSY, da_busy=1 SHALL go to WAIT_DONE.
REQ-029 In WAIT_BUSY, after BUSY_TO cycles with da_busy=0, err SHALL set and the FSM SHALL go to GAP.
REQ-030 In WAIT_DONE, da_busy=0 SHALL go to GAP and load the gap counter with GAP_CYC.
REQ-031 GAP SHALL return to IDLE when the gap counter reaches 0; with GAP_CYC=0, WAIT_DONE SHALL go directly to IDLE.
REQ-032 Latency from a request sampled in IDLE (en=1, da_busy=0, GAP done) to da_dvk high SHALL be 2 clk cycles.
REQ-033 da_dv0/da_dv1 SHALL be low in every state except ISSUE.
REQ-034 A channel with pend[k]=0 SHALL never strobe; its da_datak SHALL be held.
REQ-035 en falling mid-transaction SHALL let the in-flight transaction complete, block the next issue, and retain pend.
REQ-036 err_clr=1 SHALL clear err; a timeout in the same cycle SHALL win and leave err at 1.

Reset
REQ-037 rst_n=0 SHALL immediately force: state IDLE, da_dv0/da_dv1=0, da_data0/da_data1=0, pend=0, pdata=0, drop_cnt=0, err=0, timers=0, idle=1.
REQ-038 Reset asserted mid-transaction SHALL abort it with no further strobes; no pending value SHALL survive.

Verification
REQ-039 Single request: ctl_dv0=1, ctl_data0=0x3A5, da_busy idle -> da_dv0 pulses one cycle 2 cycles later, da_data0=0x3A5, da_dv1=0, pend=0.
REQ-040 Simultaneous request: hst_dv1=1 (0x100) and ctl_dv1=1 (0x200) in the same cycle -> da_data1=0x100, drop_cnt=1.
REQ-041 Coalescing: three ctl_dv0 codes 0x001/0x002/0x003 while da_busy=1 -> one issue with 0x003, drop_cnt=2; after 300 further overwrites, drop_cnt=255.
REQ-042 Pacing: back-to-back requests with GAP_CYC=16 and busy lasting 40 cycles -> successive da_dv pulses at least 1+busy-rise delay+40+16 cycles apart; refill arriving during ISSUE is retained.
REQ-043 Timeout: da_busy tied 0 -> err=1 after 8 cycles in WAIT_BUSY; err_clr with no new timeout -> err=0; FSM returns to IDLE.
REQ-044 Reset: rst_n low during WAIT_DONE with pend=2'b11 -> all outputs at reset values in the same cycle; no da_dv after release until a new request.
